multi_button_shaper: RTL and testbench
======================================

// Module: multi_button_shaper
// PURPOSE
//  N-channel successor to the single-button pulse shaper. Each channel synchronises a raw
//  push-button, debounces press and release, and emits exactly one clk-wide pulse per press.
//  Sits between board buttons and the pattern-matching control FSMs; one instance serves all keys.
// PARAMETERS
//  N_CH          4      number of independent button channels (>=1)
//  DB_CYCLES     16     consecutive stable samples required to accept a press/release (>=2)
//  ACTIVE_LOW    1      1: button pressed when btn_i bit==0; 0: pressed when ==1
//  REPEAT_DELAY  1000   cycles in HELD before first auto-repeat pulse (used only with MBS_AUTO_REPEAT_EN)
//  REPEAT_PERIOD 250    cycles between later auto-repeat pulses (used only with MBS_AUTO_REPEAT_EN)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  btn_i        in   N_CH   raw asynchronous button levels
//  pulse_o      out  N_CH   one-cycle press pulse per channel
//  held_o       out  N_CH   debounced pressed level per channel
//  any_pulse_o  out  1      registered OR of pulse_o, same cycle as pulse_o
// BEHAVIOUR
//  Reset (rst==1 at a clk edge): all channel FSMs -> IDLE, counters 0, 2-flop synchronisers
//   loaded with released level; pulse_o, held_o, any_pulse_o = 0 the cycle after. Reset wins
//   over every other event, including mid-debounce and mid-pulse; no pulse is emitted after reset.
//  Input path: btn_i -> 2-flop synchroniser -> 'pressed' (polarity per ACTIVE_LOW).
//  Per-channel Moore FSM, states: IDLE, DB_PRESS, PULSE, HELD, DB_RELEASE; db_cnt width clog2(DB_CYCLES).
//   IDLE:       pressed -> DB_PRESS, db_cnt=1; else stay.
//   DB_PRESS:   !pressed -> IDLE, db_cnt=0 (glitch rejected); pressed & db_cnt==DB_CYCLES-1 -> PULSE;
//               else db_cnt++.
//   PULSE:      pulse_o=1 for exactly this one cycle; unconditionally -> HELD, db_cnt=0.
//   HELD:       !pressed -> DB_RELEASE, db_cnt=1; else stay.
//   DB_RELEASE: pressed -> HELD, db_cnt=0 (bounce ignored, no new pulse);
//               !pressed & db_cnt==DB_CYCLES-1 -> IDLE; else db_cnt++.
//  held_o=1 in PULSE, HELD, DB_RELEASE. Outputs decoded from registered state (glitch-free).
//  Latency: edge 0 = first edge sampling btn_i pressed (held stable); pulse_o high in the cycle
//   after edge DB_CYCLES+1, low after edge DB_CYCLES+2. Release symmetric: held_o falls after
//   edge DB_CYCLES+1 relative to first released sample.
//  Channels fully independent; simultaneous presses give simultaneous pulses; any_pulse_o=|pulse_o.
//  Press shorter than DB_CYCLES samples: no pulse, held_o stays 0.
// CONFIGURATION
//  MBS_AUTO_REPEAT_EN defined: per-channel rpt_cnt (width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)))
//   cleared on entry to HELD, increments each HELD cycle; when rpt_cnt reaches REPEAT_DELAY-1
//   (first) or REPEAT_PERIOD-1 (thereafter) pulse_o=1 for that cycle and rpt_cnt=0. DB_RELEASE
//   freezes rpt_cnt; return to HELD resumes it. Leaving to IDLE or reset clears it.
//  Not defined: no rpt_cnt logic; exactly one pulse per accepted press; REPEAT_* ignored.
// STRUCTURE
//  Package multi_button_shaper_pkg: state encodings (IDLE=0, DB_PRESS=1, PULSE=2, HELD=3,
//   DB_RELEASE=4, 3-bit), clog2 helper function.
//  Sub-module button_shaper_ch: one synchroniser+FSM+counters; generate loop instantiates N_CH.
//  Top: generate loop, polarity handling, any_pulse_o register.
// TESTING (N_CH=4, DB_CYCLES=4, ACTIVE_LOW=1 unless noted)
//  1 Reset: rst=1 two cycles with btn_i=4'b0000 -> all outputs 0; release rst, hold btn -> first pulse after edge 5.
//  2 Clean press ch0: btn_i[0] 1->0 held 20 cycles -> pulse_o[0] high exactly 1 cycle (after edge 5), held_o[0]=1 until release+5.
//  3 Bounce: ch1 low 2 cycles, high 1, low 10 -> no pulse during bounce, single pulse 5 edges after final low sampled.
//  4 Simultaneous: ch0 and ch3 pressed same cycle -> pulse_o=4'b1001 one cycle, any_pulse_o=1 same cycle.
//  5 Reset mid-debounce: rst=1 at edge 3 of press -> no pulse; after rst release pulse 5 edges later if still pressed.
//  6 MBS_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5: hold 40 cycles -> pulses at press, +10, then every 5 cycles.

Source files
------------

// File: rtl/multi_button_shaper_pkg.sv
// multi_button_shaper_pkg
//   Shared definitions for the multi-channel button shaper.
//   - ch_state_e : per-channel FSM state encoding (3 bits)
//   - clog2_min1 : ceil(log2(v)), never less than 1, for counter widths
//   - max2       : larger of two values, for sizing the repeat counter
package multi_button_shaper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_PULSE      = 3'd2,
    ST_HELD       = 3'd3,
    ST_DB_RELEASE = 3'd4
  } ch_state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_shaper_ch.sv
// button_shaper_ch
//   One button channel: 2-flop synchroniser, debounce FSM and press pulse.
//   Optional auto-repeat while held when MBS_AUTO_REPEAT_EN is defined.
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   pressed_i    in   raw asynchronous level, 1 = pressed
//   pulse_o      out  one-cycle pulse, decoded from registered state
//   pulse_nxt_o  out  value pulse_o will take after the next clk edge
//   state_o      out  current FSM state (held level is decoded from it)
// Handshake: none; pulse_o is a plain one-cycle strobe with no back-pressure.
module button_shaper_ch
  import multi_button_shaper_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned REPEAT_DELAY  = 1000,
  parameter int unsigned REPEAT_PERIOD = 250
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pressed_i,
  output logic      pulse_o,
  output logic      pulse_nxt_o,
  output ch_state_e state_o
);

  localparam int unsigned CW = clog2_min1(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  ch_state_e     state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= ST_IDLE;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= pressed_i;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d  = ST_DB_PRESS;
          db_cnt_d = CW'(1);
        end
      end
      ST_DB_PRESS: begin
        if (!sync2_q) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = ST_PULSE;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_PULSE: begin
        state_d  = ST_HELD;
        db_cnt_d = '0;
      end
      ST_HELD: begin
        if (!sync2_q) begin
          state_d  = ST_DB_RELEASE;
          db_cnt_d = CW'(1);
        end
      end
      ST_DB_RELEASE: begin
        // A bounce back to pressed returns to HELD without a new pulse.
        if (sync2_q) begin
          state_d  = ST_HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  assign state_o = state_q;

`ifdef MBS_AUTO_REPEAT_EN
  localparam int unsigned RW = clog2_min1(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  // first_q selects the initial (longer) repeat interval.
  logic [RW-1:0] rpt_q, rpt_d;
  logic          first_q, first_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    rpt_d   = rpt_q;
    first_d = first_q;
    case (state_q)
      ST_PULSE: begin
        rpt_d   = '0;
        first_d = 1'b1;
      end
      ST_HELD: begin
        if (rpt_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
          rpt_d   = '0;
          first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        // Count is frozen while debouncing release; cleared once released.
        if (state_d == ST_IDLE) begin
          rpt_d   = '0;
          first_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pulse_o     = (state_q == ST_PULSE) ||
                       ((state_q == ST_HELD) && (rpt_q == (first_q ? DELAY_LAST : PERIOD_LAST)));
  assign pulse_nxt_o = (state_d == ST_PULSE) ||
                       ((state_d == ST_HELD) && (rpt_d == (first_d ? DELAY_LAST : PERIOD_LAST)));
`else
  assign pulse_o     = (state_q == ST_PULSE);
  assign pulse_nxt_o = (state_d == ST_PULSE);
`endif

endmodule

// File: rtl/multi_button_shaper.sv
// multi_button_shaper
//   N-channel push-button shaper: synchronise, debounce press and release,
//   and emit one clk-wide pulse per accepted press on each channel.
//   Optional feature macro: MBS_AUTO_REPEAT_EN (auto-repeat pulses while held).
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous reset, active-high
//   btn_i        in   N_CH   raw asynchronous button levels
//   pulse_o      out  N_CH   one-cycle press pulse per channel
//   held_o       out  N_CH   debounced pressed level per channel
//   any_pulse_o  out  1      registered OR of pulse_o, aligned with pulse_o
module multi_button_shaper
  import multi_button_shaper_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DB_CYCLES     = 16,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 1000,
  parameter int unsigned REPEAT_PERIOD = 250
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] pulse_o,
  output logic [N_CH-1:0] held_o,
  output logic            any_pulse_o
);

  if (N_CH < 1 || DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("multi_button_shaper: illegal parameter value");
  end

  // Channels work in the "1 = pressed" domain, so their synchronisers
  // reset to the released level whatever the board polarity is.
  logic [N_CH-1:0] pressed_raw;
  logic [N_CH-1:0] pulse_nxt;
  logic            any_pulse_q;

  assign pressed_raw = ACTIVE_LOW ? ~btn_i : btn_i;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_state_e ch_state;

    button_shaper_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .pressed_i  (pressed_raw[g]),
      .pulse_o    (pulse_o[g]),
      .pulse_nxt_o(pulse_nxt[g]),
      .state_o    (ch_state)
    );

    assign held_o[g] = (ch_state == ST_PULSE) || (ch_state == ST_HELD) ||
                       (ch_state == ST_DB_RELEASE);
  end

  // Registered from the channels' next-cycle pulse so it lines up with pulse_o.
  always_ff @(posedge clk) begin
    if (rst) any_pulse_q <= 1'b0;
    else     any_pulse_q <= |pulse_nxt;
  end

  assign any_pulse_o = any_pulse_q;

endmodule

// File: tb/tb_multi_button_shaper.sv
// tb_multi_button_shaper
//   Bench for multi_button_shaper (N_CH=4, DB_CYCLES=4, ACTIVE_LOW=1,
//   REPEAT_DELAY=10, REPEAT_PERIOD=5). Auto-repeat checks are compiled in
//   when MBS_AUTO_REPEAT_EN is defined.
module tb_multi_button_shaper;

  localparam int N_CH = 4;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;
  localparam int EW   = 2 * N_CH + 1;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] btn_i = '1;
  logic [N_CH-1:0] pulse_o, held_o;
  logic            any_pulse_o;

  always #5 clk = ~clk;

  multi_button_shaper #(
    .N_CH         (N_CH),
    .DB_CYCLES    (DB),
    .ACTIVE_LOW   (1'b1),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (btn_i),
    .pulse_o    (pulse_o),
    .held_o     (held_o),
    .any_pulse_o(any_pulse_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Debounce as a run-length rule: the accepted level flips once DB
  // consecutive synchronised samples disagree with it. The synchroniser is
  // a two-sample delay, and the sample right after an accepted press is
  // not examined (that cycle is the pulse cycle).
  logic [EW-1:0]   exp_q[$];
  logic [N_CH-1:0] m_d1, m_d2;
  logic [N_CH-1:0] m_lvl, m_skip;
  int              m_run[N_CH];
`ifdef MBS_AUTO_REPEAT_EN
  int              m_hc[N_CH];
  int              m_tgt[N_CH];
`endif

  task automatic model_edge(input logic [N_CH-1:0] press);
    logic [N_CH-1:0] smp, p;
    p = '0;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_skip = '0;
      for (int c = 0; c < N_CH; c++) m_run[c] = 0;
    end else begin
      smp  = m_d2;
      m_d2 = m_d1;
      m_d1 = press;
      for (int c = 0; c < N_CH; c++) begin
        if (m_skip[c]) begin
          m_skip[c] = 1'b0;
        end else if (smp[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_lvl[c] = smp[c];
            m_run[c] = 0;
            if (smp[c]) begin
              p[c]      = 1'b1;
              m_skip[c] = 1'b1;
`ifdef MBS_AUTO_REPEAT_EN
              m_hc[c]  = 0;
              m_tgt[c] = RD;
`endif
            end
          end
        end else begin
          m_run[c] = 0;
        end
`ifdef MBS_AUTO_REPEAT_EN
        // Count cycles spent steadily held (not pulsing, not release-debouncing).
        if (m_lvl[c] && !m_skip[c] && m_run[c] == 0) begin
          m_hc[c]++;
          if (m_hc[c] == m_tgt[c]) begin
            p[c]     = 1'b1;
            m_hc[c]  = 0;
            m_tgt[c] = RP;
          end
        end
`endif
      end
    end
    exp_q.push_back({|p, m_lvl, p});
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic [N_CH-1:0] press);
    btn_i = ~press;
    @(posedge clk);
    model_edge(press);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EW-1:0] e;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(4'b1111);
      e = exp_q.pop_front();
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== {EW{1'b0}} || e !== {EW{1'b0}}) begin
        n_err++;
        $display("FAIL reset_outputs i=%0d got %b expected %b", i, {any_pulse_o, held_o, pulse_o}, {EW{1'b0}});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b1111);
      e = exp_q.pop_front();
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== e) begin
        n_err++;
        $display("FAIL reset_release_model i=%0d got %b expected %b", i, {any_pulse_o, held_o, pulse_o}, e);
      end
      n_cmp++;
      if (pulse_o !== ((i == 5) ? 4'b1111 : 4'b0000)) begin
        n_err++;
        $display("FAIL reset_first_pulse i=%0d got %b expected %b", i, pulse_o, (i == 5) ? 4'b1111 : 4'b0000);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000);
      e = exp_q.pop_front();
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== e || held_o !== ((i < 5) ? 4'b1111 : 4'b0000)) begin
        n_err++;
        $display("FAIL reset_release_all i=%0d got %b expected %b", i, {any_pulse_o, held_o, pulse_o}, e);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [EW-1:0] e;
    for (int i = 0; i < 32; i++) begin
      tick((i < 20) ? 4'b0001 : 4'b0000);
      e = exp_q.pop_front();
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== e) begin
        n_err++;
        $display("FAIL clean_model i=%0d got %b expected %b", i, {any_pulse_o, held_o, pulse_o}, e);
      end
      n_cmp++;
      if (pulse_o[0] !== (i == 5) || held_o[0] !== (i >= 5 && i < 25)) begin
        n_err++;
        $display("FAIL clean_timing i=%0d got pulse=%b held=%b expected pulse=%b held=%b",
                 i, pulse_o[0], held_o[0], i == 5, (i >= 5 && i < 25));
      end
    end
  endtask

  task automatic test_bounce();
    logic [EW-1:0] e;
    logic [N_CH-1:0] pr;
    for (int i = 0; i < 26; i++) begin
      pr = (i == 2 || i >= 13) ? 4'b0000 : 4'b0010;
      tick(pr);
      e = exp_q.pop_front();
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== e) begin
        n_err++;
        $display("FAIL bounce_model i=%0d got %b expected %b", i, {any_pulse_o, held_o, pulse_o}, e);
      end
      n_cmp++;
      if (pulse_o[1] !== (i == 8)) begin
        n_err++;
        $display("FAIL bounce_pulse i=%0d got %b expected %b", i, pulse_o[1], i == 8);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [EW-1:0] e;
    for (int i = 0; i < 24; i++) begin
      tick((i < 12) ? 4'b1001 : 4'b0000);
      e = exp_q.pop_front();
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== e) begin
        n_err++;
        $display("FAIL simul_model i=%0d got %b expected %b", i, {any_pulse_o, held_o, pulse_o}, e);
      end
      n_cmp++;
      if ({any_pulse_o, pulse_o} !== ((i == 5) ? 5'b11001 : 5'b00000)) begin
        n_err++;
        $display("FAIL simul_pulse i=%0d got %b expected %b", i, {any_pulse_o, pulse_o},
                 (i == 5) ? 5'b11001 : 5'b00000);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [EW-1:0] e;
    for (int i = 0; i < 28; i++) begin
      rst = (i == 3);
      tick((i < 16) ? 4'b0100 : 4'b0000);
      e = exp_q.pop_front();
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== e) begin
        n_err++;
        $display("FAIL rstmid_model i=%0d got %b expected %b", i, {any_pulse_o, held_o, pulse_o}, e);
      end
      n_cmp++;
      if (pulse_o[2] !== (i == 9)) begin
        n_err++;
        $display("FAIL rstmid_pulse i=%0d got %b expected %b", i, pulse_o[2], i == 9);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [EW-1:0] e;
    logic [N_CH-1:0] pr;
    pr = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 5) == 0) pr[c] = ~pr[c];
      rst = ($urandom_range(0, 149) == 0);
      tick(pr);
      e = exp_q.pop_front();
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== e) begin
        n_err++;
        $display("FAIL random_model i=%0d press=%b got %b expected %b", i, pr, {any_pulse_o, held_o, pulse_o}, e);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(4'b0000);
      e = exp_q.pop_front();
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== e) begin
        n_err++;
        $display("FAIL random_drain i=%0d got %b expected %b", i, {any_pulse_o, held_o, pulse_o}, e);
      end
    end
  endtask

`ifdef MBS_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    logic [EW-1:0] e;
    logic exp_p;
    for (int i = 0; i < 52; i++) begin
      tick((i < 40) ? 4'b0001 : 4'b0000);
      e = exp_q.pop_front();
      exp_p = (i == 5) || (i >= 15 && i <= 41 && ((i - 15) % 5) == 0);
      n_cmp++;
      if ({any_pulse_o, held_o, pulse_o} !== e) begin
        n_err++;
        $display("FAIL repeat_model i=%0d got %b expected %b", i, {any_pulse_o, held_o, pulse_o}, e);
      end
      n_cmp++;
      if (pulse_o[0] !== exp_p) begin
        n_err++;
        $display("FAIL repeat_pulse i=%0d got %b expected %b", i, pulse_o[0], exp_p);
      end
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_skip = '0;
    for (int c = 0; c < N_CH; c++) m_run[c] = 0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
`ifdef MBS_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
